// File: rtl/acl_spi_pkg.sv
// Shared constants for the ADXL362-style SPI responder: commands, register map,
// FSM state encoding and reset values.
package acl_spi_pkg;

  localparam logic [7:0] CMD_RD = 8'h0B;
  localparam logic [7:0] CMD_WR = 8'h0A;

  localparam logic [5:0] ADDR_DEVID_AD   = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST  = 6'h01;
  localparam logic [5:0] ADDR_PARTID     = 6'h02;
  localparam logic [5:0] ADDR_XDATA      = 6'h08;
  localparam logic [5:0] ADDR_YDATA      = 6'h09;
  localparam logic [5:0] ADDR_ZDATA      = 6'h0A;
  localparam logic [5:0] ADDR_XDATA_L    = 6'h0E;
  localparam logic [5:0] ADDR_XDATA_H    = 6'h0F;
  localparam logic [5:0] ADDR_YDATA_L    = 6'h10;
  localparam logic [5:0] ADDR_YDATA_H    = 6'h11;
  localparam logic [5:0] ADDR_ZDATA_L    = 6'h12;
  localparam logic [5:0] ADDR_ZDATA_H    = 6'h13;
  localparam logic [5:0] ADDR_FILTER_CTL = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL  = 6'h2D;

  localparam logic [7:0] FILTER_CTL_RST = 8'h13;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, ERR} spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin, with single-cycle rise/fall pulses
// derived from the synchronized level.
module spi_pin_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic ClkPort,
  input  logic Reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/acl_spi_responder.sv
// SPI mode-0 responder emulating the ADXL362 register read/write subset.
// All logic runs on ClkPort; the SPI pins are oversampled.
module acl_spi_responder
  import acl_spi_pkg::*;
#(
  parameter logic [7:0]  DEVID_AD    = 8'hAD,
  parameter logic [7:0]  DEVID_MST   = 8'h1D,
  parameter logic [7:0]  PARTID      = 8'hF2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [11:0] acl_x,
  input  logic [11:0] acl_y,
  input  logic [11:0] acl_z,
  output logic [7:0]  power_ctl,
  output logic [7:0]  filter_ctl,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        cmd_error,
  output logic        busy
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .pin     (sclk),
    .level   (sclk_lvl),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // cs_n resets to the asserted level so a pin already low when Reset drops
  // produces no fall; the FSM waits for a genuine new frame.
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .pin     (cs_n),
    .level   (cs_lvl),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .pin     (mosi),
    .level   (mosi_s),
    .rise    (mosi_rise),
    .fall    (mosi_fall)
  );

  logic unused_pins;
  assign unused_pins = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

  spi_state_e  state;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx;
  logic [7:0]  rx_next;
  logic [7:0]  tx;
  logic [5:0]  ptr;
  logic        is_rd;
  logic        byte_done;
  logic [11:0] snap_x, snap_y, snap_z;
  logic [7:0]  rd_byte;

  function automatic logic [7:0] reg_read(input logic [5:0]  a,
                                          input logic [11:0] x,
                                          input logic [11:0] y,
                                          input logic [11:0] z,
                                          input logic [7:0]  fc,
                                          input logic [7:0]  pc);
    logic [7:0] d;
    case (a)
      ADDR_DEVID_AD:   d = DEVID_AD;
      ADDR_DEVID_MST:  d = DEVID_MST;
      ADDR_PARTID:     d = PARTID;
      ADDR_XDATA:      d = x[11:4];
      ADDR_YDATA:      d = y[11:4];
      ADDR_ZDATA:      d = z[11:4];
      ADDR_XDATA_L:    d = x[7:0];
      ADDR_XDATA_H:    d = {{4{x[11]}}, x[11:8]};
      ADDR_YDATA_L:    d = y[7:0];
      ADDR_YDATA_H:    d = {{4{y[11]}}, y[11:8]};
      ADDR_ZDATA_L:    d = z[7:0];
      ADDR_ZDATA_H:    d = {{4{z[11]}}, z[11:8]};
      ADDR_FILTER_CTL: d = fc;
      ADDR_POWER_CTL:  d = pc;
      default:         d = 8'h00;
    endcase
    return d;
  endfunction

  assign rx_next = {rx, mosi_s};
  assign rd_byte = reg_read(ptr, snap_x, snap_y, snap_z, filter_ctl, power_ctl);
  assign busy    = (state != IDLE);

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      rx         <= 7'd0;
      tx         <= 8'd0;
      ptr        <= 6'd0;
      is_rd      <= 1'b0;
      byte_done  <= 1'b0;
      snap_x     <= 12'd0;
      snap_y     <= 12'd0;
      snap_z     <= 12'd0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      power_ctl  <= 8'h00;
      filter_ctl <= FILTER_CTL_RST;
      wr_strobe  <= 1'b0;
      wr_addr    <= 6'd0;
      wr_data    <= 8'd0;
      cmd_error  <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (cs_rise) begin
        state   <= IDLE;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else if (cs_fall) begin
        state     <= CMD;
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        snap_x    <= acl_x;
        snap_y    <= acl_y;
        snap_z    <= acl_z;
        cmd_error <= 1'b0;
        miso      <= 1'b0;
        miso_oe   <= 1'b1;
      end else if (sclk_rise && state != IDLE && state != ERR) begin
        rx      <= rx_next[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          case (state)
            CMD: begin
              if (rx_next == CMD_RD) begin
                state <= ADDR;
                is_rd <= 1'b1;
              end else if (rx_next == CMD_WR) begin
                state <= ADDR;
                is_rd <= 1'b0;
              end else begin
                state     <= ERR;
                cmd_error <= 1'b1;
              end
            end
            ADDR: begin
              ptr   <= rx_next[5:0];
              state <= is_rd ? RDATA : WDATA;
            end
            RDATA: ptr <= ptr + 6'd1;
            WDATA: begin
              wr_strobe <= 1'b1;
              wr_addr   <= ptr;
              wr_data   <= rx_next;
              if (ptr == ADDR_POWER_CTL)  power_ctl  <= rx_next;
              if (ptr == ADDR_FILTER_CTL) filter_ctl <= rx_next;
              ptr <= ptr + 6'd1;
            end
            default: ;
          endcase
        end
      end else if (sclk_fall) begin
        byte_done <= 1'b0;
        // A byte boundary in RDATA loads the next register; otherwise keep shifting.
        if (state == RDATA) begin
          if (byte_done) begin
            miso <= rd_byte[7];
            tx   <= {rd_byte[6:0], 1'b0};
          end else begin
            miso <= tx[7];
            tx   <= {tx[6:0], 1'b0};
          end
        end else begin
          miso <= 1'b0;
        end
      end
    end
  end

endmodule
